// File: rtl/multi_cycle_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_ctrl_pkg
// Shared encodings for the RV32I multi-cycle control unit:
//   - base opcode constants (bits [6:0] of the instruction)
//   - ALU operation codes ({funct7[5], funct3} style)
//   - register-file write-data source select (rfwd_sel_e)
//   - FSM state constants (legacy-compatible localparams) and a matching
//     state_e enum for readable debug/trace code
//   - instruction-class enum plus a classify() helper used by the FSM
// Ports: none (package).
// -----------------------------------------------------------------------------
package rv32i_ctrl_pkg;

    // Base opcodes
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_AU = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JL = 7'b1100111;

    // ALU operation codes: bit 3 is funct7[5] (SUB/SRA), bits 2:0 are funct3
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // funct3 value shared by the SRL/SRA (and SRLI/SRAI) pair
    localparam logic [2:0] F3_SR = 3'b101;

    // Register-file write-data source
    typedef enum logic [2:0] {
        RFWD_ALU    = 3'd0,
        RFWD_MEM    = 3'd1,
        RFWD_IMM    = 3'd2,
        RFWD_PC_IMM = 3'd3,
        RFWD_PC_4   = 3'd4
    } rfwd_sel_e;

    // FSM state encodings
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXE    = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    typedef enum logic [2:0] {
        FETCH  = ST_FETCH,
        DECODE = ST_DECODE,
        EXE    = ST_EXE,
        MEM    = ST_MEM,
        WB     = ST_WB,
        TRAP   = ST_TRAP
    } state_e;

    // Instruction classes as seen by the sequencer
    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_L       = 4'd2,
        CLS_S       = 4'd3,
        CLS_B       = 4'd4,
        CLS_LU      = 4'd5,
        CLS_AU      = 4'd6,
        CLS_J       = 4'd7,
        CLS_JL      = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_e;

    function automatic instr_class_e classify(input logic [6:0] opcode);
        instr_class_e cls;
        case (opcode)
            OP_R:    cls = CLS_R;
            OP_I:    cls = CLS_I;
            OP_L:    cls = CLS_L;
            OP_S:    cls = CLS_S;
            OP_B:    cls = CLS_B;
            OP_LU:   cls = CLS_LU;
            OP_AU:   cls = CLS_AU;
            OP_J:    cls = CLS_J;
            OP_JL:   cls = CLS_JL;
            default: cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_unit_if
// Bundle between the control unit and the RV32I datapath.
//   instrCode      32  current instruction (datapath -> control)
//   regFileWe       1  register-file write strobe
//   aluControl      4  ALU op select
//   aluSrcMuxSel    1  0 = rs2, 1 = immediate
//   RFWDSrcMuxSel   3  0 alu, 1 mem, 2 imm, 3 PC+imm, 4 PC+4
//   branch          1  conditional-branch qualifier
//   jal             1  force PC <- PC_Imm adder result
//   jalr            1  PC_Imm adder base = rs1
//   pcEn            1  PC load strobe, one pulse per instruction
//   dataWe          1  data-memory write strobe
//   illegalInstr    1  sticky illegal-opcode flag
// Modports: master = control unit, slave = datapath side.
// -----------------------------------------------------------------------------
interface multi_cycle_control_unit_if;
    logic [31:0] instrCode;
    logic        regFileWe;
    logic [3:0]  aluControl;
    logic        aluSrcMuxSel;
    logic [2:0]  RFWDSrcMuxSel;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        pcEn;
    logic        dataWe;
    logic        illegalInstr;

    modport master (
        input  instrCode,
        output regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
        output branch, jal, jalr, pcEn, dataWe, illegalInstr
    );

    modport slave (
        output instrCode,
        input  regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
        input  branch, jal, jalr, pcEn, dataWe, illegalInstr
    );
endinterface

// File: rtl/multi_cycle_control_unit_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Purely combinational: maps opcode/funct3/funct7[5] to the ALU op select.
//   opcode_i       in   7  instruction bits [6:0]
//   funct3_i       in   3  instruction bits [14:12]
//   funct7_5_i     in   1  instruction bit 30
//   alu_control_o  out  4  ALU op select
// -----------------------------------------------------------------------------
module alu_decoder
    import rv32i_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (opcode_i)
            OP_R: alu_control_o = {funct7_5_i, funct3_i};
            // Only the shift-right immediates carry a meaningful funct7[5];
            // for every other I-type funct3 that bit is immediate data.
            OP_I: alu_control_o = {(funct3_i == F3_SR) ? funct7_5_i : 1'b0, funct3_i};
            // Branch compare selects the comparator via funct3 only.
            OP_B: alu_control_o = {1'b0, funct3_i};
            // Loads/stores compute base + offset; U/J types do not use the ALU.
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_unit
// Control FSM for the RV32I multi-cycle core. Each instruction walks
// FETCH -> DECODE -> EXE -> [MEM] -> WB and retires with exactly one pcEn
// pulse (in WB, or in MEM for stores). Selects are decoded combinationally
// from instrCode outside FETCH; strobes are gated by state.
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-low reset
//   bus     master modport of multi_cycle_control_unit_if
// Build option ILLEGAL_TRAP_EN:
//   defined   - unknown opcode goes DECODE -> TRAP, raises illegalInstr and
//               stays there until reset
//   undefined - unknown opcode goes DECODE -> WB as a NOP, illegalInstr = 0
// -----------------------------------------------------------------------------
module multi_cycle_control_unit
    import rv32i_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    multi_cycle_control_unit_if.master  bus
);

    logic [2:0]   state_q;
    logic [2:0]   state_d;
    instr_class_e instr_cls;
    logic [3:0]   alu_op;
    logic         in_fetch;

    // Fields that only the datapath (immediates, register indices) consumes.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instrCode[31], bus.instrCode[29:15],
                                 bus.instrCode[11:7]};

    assign instr_cls = classify(bus.instrCode[6:0]);
    assign in_fetch  = (state_q == ST_FETCH);

    alu_decoder u_alu_decoder (
        .opcode_i      (bus.instrCode[6:0]),
        .funct3_i      (bus.instrCode[14:12]),
        .funct7_5_i    (bus.instrCode[30]),
        .alu_control_o (alu_op)
    );

    // ------------------------------------------------------------------
    // State register. Reset is asynchronous so that every strobe, which is
    // a function of state, drops the moment reset is asserted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (instr_cls == CLS_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    // Treated as a NOP: skip straight to the retire cycle.
                    state_d = ST_WB;
`endif
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                if (instr_cls == CLS_L || instr_cls == CLS_S) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                // Stores retire from MEM; loads still need the WB write.
                if (instr_cls == CLS_L) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:   state_d = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Illegal-instruction flag
    // ------------------------------------------------------------------
`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_d;

    assign illegal_d = illegal_q | (state_d == ST_TRAP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign bus.illegalInstr = illegal_q;
`else
    assign bus.illegalInstr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Decoded selects: held at 0 in FETCH because instrCode may still be
    // settling after the previous PC load.
    // ------------------------------------------------------------------
    logic      alu_src;
    rfwd_sel_e rfwd_sel;
    logic      branch_sel;
    logic      jal_sel;
    logic      jalr_sel;

    always_comb begin
        alu_src    = 1'b0;
        rfwd_sel   = RFWD_ALU;
        branch_sel = 1'b0;
        jal_sel    = 1'b0;
        jalr_sel   = 1'b0;
        if (!in_fetch) begin
            case (instr_cls)
                CLS_I:  alu_src = 1'b1;
                CLS_L: begin
                    alu_src  = 1'b1;
                    rfwd_sel = RFWD_MEM;
                end
                CLS_S:  alu_src = 1'b1;
                CLS_B:  branch_sel = 1'b1;
                CLS_LU: rfwd_sel = RFWD_IMM;
                CLS_AU: rfwd_sel = RFWD_PC_IMM;
                CLS_J: begin
                    rfwd_sel = RFWD_PC_4;
                    jal_sel  = 1'b1;
                end
                CLS_JL: begin
                    // jalr reuses the jal PC path with rs1 as the adder base.
                    rfwd_sel = RFWD_PC_4;
                    jal_sel  = 1'b1;
                    jalr_sel = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.aluControl    = in_fetch ? ALU_ADD : alu_op;
    assign bus.aluSrcMuxSel  = alu_src;
    assign bus.RFWDSrcMuxSel = rfwd_sel;
    assign bus.branch        = branch_sel;
    assign bus.jal           = jal_sel;
    assign bus.jalr          = jalr_sel;

    // ------------------------------------------------------------------
    // Strobes
    // ------------------------------------------------------------------
    logic writes_rd;

    always_comb begin
        case (instr_cls)
            CLS_R, CLS_I, CLS_L, CLS_LU, CLS_AU, CLS_J, CLS_JL: writes_rd = 1'b1;
            default:                                            writes_rd = 1'b0;
        endcase
    end

    assign bus.regFileWe = (state_q == ST_WB) && writes_rd;
    assign bus.dataWe    = (state_q == ST_MEM) && (instr_cls == CLS_S);
    // A store never reaches WB, so WB alone covers every other class
    // (including the illegal-as-NOP path).
    assign bus.pcEn      = (state_q == ST_WB) ||
                           ((state_q == ST_MEM) && (instr_cls == CLS_S));

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_control_unit
// Directed and randomized stimulus for multi_cycle_control_unit. For every
// instruction the bench derives the expected phase sequence from the
// instruction class (F D E [M] W, or F D T... when ILLEGAL_TRAP_EN traps) and
// the expected output vector for each phase, then compares it every cycle.
// -----------------------------------------------------------------------------
module tb_multi_cycle_control_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multi_cycle_control_unit_if bus ();

    multi_cycle_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // {regFileWe, aluControl[3:0], aluSrc, RFWD[2:0], branch, jal, jalr, pcEn, dataWe, illegal}
    logic [14:0] obs;
    assign obs = {bus.regFileWe, bus.aluControl, bus.aluSrcMuxSel, bus.RFWDSrcMuxSel,
                  bus.branch, bus.jal, bus.jalr, bus.pcEn, bus.dataWe, bus.illegalInstr};

    // Instruction kinds for the model
    localparam int K_R = 0, K_I = 1, K_L = 2, K_S = 3, K_B = 4;
    localparam int K_LU = 5, K_AU = 6, K_J = 7, K_JL = 8, K_X = 9;

    logic [6:0] op_table [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                 7'h37, 7'h17, 7'h6F, 7'h67};
    logic [6:0] bad_ops  [3] = '{7'h7F, 7'h0B, 7'h00};

    function automatic int kind_of(input logic [31:0] ins);
        for (int k = 0; k < 9; k++)
            if (ins[6:0] == op_table[k]) return k;
        return K_X;
    endfunction

    function automatic string trace_of(input logic [31:0] ins);
        case (kind_of(ins))
            K_L: return "FDEMW";
            K_S: return "FDEM";
`ifdef ILLEGAL_TRAP_EN
            K_X: return "FDTTTTTT";
`else
            K_X: return "FDW";
`endif
            default: return "FDEW";
        endcase
    endfunction

    function automatic logic [14:0] model(input byte ph, input logic [31:0] ins);
        int         k;
        logic [2:0] f3;
        logic       f7b;
        logic       we, src, br, jl, jr, pc, dwe, ill;
        logic [3:0] alu;
        logic [2:0] rf;
        k   = kind_of(ins);
        f3  = ins[14:12];
        f7b = ins[30];
        if (ph == "F") return 15'd0;
        alu = 4'd0; src = 0; rf = 3'd0; br = 0; jl = 0; jr = 0;
        case (k)
            K_R:  alu = {f7b, f3};
            K_I:  begin alu = {(f3 == 3'd5) ? f7b : 1'b0, f3}; src = 1; end
            K_L:  begin src = 1; rf = 3'd1; end
            K_S:  src = 1;
            K_B:  begin alu = {1'b0, f3}; br = 1; end
            K_LU: rf = 3'd2;
            K_AU: rf = 3'd3;
            K_J:  begin rf = 3'd4; jl = 1; end
            K_JL: begin rf = 3'd4; jl = 1; jr = 1; end
            default: ;
        endcase
        we  = (ph == "W") && !(k == K_S || k == K_B || k == K_X);
        pc  = (ph == "W") || (ph == "M" && k == K_S);
        dwe = (ph == "M") && (k == K_S);
        ill = (ph == "T");
        return {we, alu, src, rf, br, jl, jr, pc, dwe, ill};
    endfunction

    task automatic check(input string tag, input int idx, input logic [14:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves at the negedge after
    // the last phase of the trace.
    task automatic run_instr(input logic [31:0] ins, input string tag);
        string tr;
        tr = trace_of(ins);
        bus.instrCode = ins;
        for (int i = 0; i < tr.len(); i++) begin
            #1;
            check(tag, i, model(tr[i], ins));
            @(negedge clk);
        end
        $display("instr %08h %-10s trace %s", ins, tag, tr);
    endtask

    // Walk an instruction up to the given phase, then pull reset there.
    task automatic reset_in_phase(input logic [31:0] ins, input int stop, input string tag);
        string tr;
        tr = trace_of(ins);
        bus.instrCode = ins;
        for (int i = 0; i <= stop; i++) begin
            #1;
            check(tag, i, model(tr[i], ins));
            if (i < stop) @(negedge clk);
        end
        #1 reset = 1'b0;
        #1 check({tag, "_rst"}, stop, 15'd0);
        @(posedge clk);
        #1 check({tag, "_hold"}, stop, 15'd0);
        @(negedge clk);
        reset = 1'b1;
        $display("instr %08h %-10s reset in phase %c", ins, tag, tr[stop]);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        int          k;

        reset         = 1'b0;
        bus.instrCode = 32'h0000_0013;
        #2 check("reset", 0, 15'd0);
        repeat (2) @(negedge clk);
        check("reset_clk", 0, 15'd0);
        reset = 1'b1;

        // Directed cases
        run_instr(32'h002081B3, "add");
        run_instr(32'h0020A423, "sw");
        run_instr(32'h0080A283, "lw");
        run_instr(32'h00108463, "beq");
        run_instr(32'h402081B3, "sub");
        run_instr(32'h4020D193, "srai");
        run_instr(32'h4000C193, "xori_b30");
        run_instr(32'h123450B7, "lui");
        run_instr(32'h00001097, "auipc");
        run_instr(32'h008000EF, "jal");
        run_instr(32'h000080E7, "jalr");

        // Reset mid-instruction: during EXE of the add, then during WB of sub
        reset_in_phase(32'h002081B3, 2, "add_exe");
        run_instr(32'h002081B3, "add_after");
        reset_in_phase(32'h402081B3, 3, "sub_wb");
        reset_in_phase(32'h0020A423, 3, "sw_mem");
        run_instr(32'h0080A283, "lw_after");

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            r = $urandom();
`ifdef ILLEGAL_TRAP_EN
            k = $urandom_range(0, 8);
`else
            k = $urandom_range(0, 9);
`endif
            if (k == 9) ins = {r[31:7], bad_ops[$urandom_range(0, 2)]};
            else        ins = {r[31:7], op_table[k]};
            run_instr(ins, "rand");
        end

        // Unknown opcode: trap or NOP depending on build
        run_instr(32'hFFFFFFFF, "illegal");
`ifdef ILLEGAL_TRAP_EN
        #1 reset = 1'b0;
        #1 check("trap_rst", 0, 15'd0);
        @(negedge clk);
        reset = 1'b1;
`endif
        run_instr(32'h002081B3, "add_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
